glyph_stroke_plotter: RTL and testbench

- Parametrised stroke-glyph animator for the 160x120 VGA adapter path; generalises the fixed single-letter stroke drawer into a table-driven engine.
- Holds up to MAX_SEG programmable line segments (8 directions, length 0-15) relative to a run-time origin.
- Emits one pixel per TICK_DIV clocks with a plot strobe, and supports draw/erase mode, abort and an off-screen clip.
- Sits between game control and vga_adapter: x, y, colour and plot feed the adapter directly.

---
 rtl/glyph_stroke_plotter.sv | 194 +++++++++++++++++++
 tb/tb_glyph_stroke_plotter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_stroke_plotter.sv
// Table-driven stroke-glyph animator for the 160x120 VGA adapter path.
// Walks up to MAX_SEG line segments from a run-time origin, emitting one pixel per TICK_DIV clocks.
module glyph_stroke_plotter #(
   parameter int unsigned X_W      = 8,
   parameter int unsigned Y_W      = 7,
   parameter int unsigned MAX_SEG  = 8,
   parameter int unsigned TICK_DIV = 3125000,
   parameter int unsigned X_LIM    = 160,
   parameter int unsigned Y_LIM    = 120
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       seg_we,
   input  logic [$clog2(MAX_SEG)-1:0] seg_addr,
   input  logic [14:0]                seg_data,
   input  logic                       start,
   input  logic [$clog2(MAX_SEG):0]   num_seg,
   input  logic [X_W-1:0]             x0,
   input  logic [Y_W-1:0]             y0,
   input  logic [2:0]                 colour_in,
   input  logic                       erase,
   input  logic                       abort,
   output logic [X_W-1:0]             x,
   output logic [Y_W-1:0]             y,
   output logic [2:0]                 colour,
   output logic                       plot,
   output logic                       busy,
   output logic                       done
);

   localparam int unsigned IdxW = $clog2(MAX_SEG);
   localparam int unsigned DivW = $clog2(TICK_DIV);
   localparam logic [IdxW:0] MaxNum  = (IdxW+1)'(MAX_SEG);
   localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);
   localparam logic [X_W:0] XLim = (X_W+1)'(X_LIM);
   localparam logic [Y_W:0] YLim = (Y_W+1)'(Y_LIM);

   typedef enum logic [2:0] {StIdle, StLoad, StPlot, StNext, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [IdxW:0]     num_q, num_d;
   logic [X_W-1:0]    x0_q, x0_d, cx_q, cx_d, x_q, x_d;
   logic [Y_W-1:0]    y0_q, y0_d, cy_q, cy_d, y_q, y_d;
   logic [2:0]        colour_q, colour_d, dir_q, dir_d;
   logic [3:0]        rem_q, rem_d;
   logic [DivW-1:0]   div_q, div_d;
   logic              zdone_q, zdone_d;
   logic [14:0]       tbl_q [MAX_SEG];
   logic [14:0]       rd_q;
   logic [X_W-1:0]    step_x;
   logic [Y_W-1:0]    step_y;
   logic              slot;

   assign slot = (state_q == StPlot) && (div_q == DivLast);

   // Table has no reset; the read port prefetches the entry the FSM will use next.
   always_ff @(posedge clk) begin
      if (seg_we && !busy) tbl_q[seg_addr] <= seg_data;
      rd_q <= tbl_q[idx_d];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         num_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         dir_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         zdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         num_q    <= num_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         dir_q    <= dir_d;
         rem_q    <= rem_d;
         div_q    <= div_d;
         zdone_q  <= zdone_d;
      end
   end

   always_comb begin
      step_x = '0;
      step_y = '0;
      case (dir_q)
         3'd0:    step_x = X_W'(1);
         3'd1:    begin step_x = X_W'(1); step_y = Y_W'(1); end
         3'd2:    step_y = Y_W'(1);
         3'd3:    begin step_x = '1;      step_y = Y_W'(1); end
         3'd4:    step_x = '1;
         3'd5:    begin step_x = '1;      step_y = '1;      end
         3'd6:    step_y = '1;
         default: begin step_x = X_W'(1); step_y = '1;      end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      num_d    = num_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      dir_d    = dir_q;
      rem_d    = rem_q;
      div_d    = div_q;
      zdone_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start && !abort) begin
               if (num_seg == '0) begin
                  zdone_d = 1'b1;
               end else begin
                  num_d    = (num_seg > MaxNum) ? MaxNum : num_seg;
                  x0_d     = x0;
                  y0_d     = y0;
                  colour_d = erase ? 3'b000 : colour_in;
                  idx_d    = '0;
                  state_d  = StLoad;
               end
            end
         end
         StLoad: begin
            cx_d    = x0_q + X_W'(rd_q[14:11]);
            cy_d    = y0_q + Y_W'(rd_q[10:7]);
            dir_d   = rd_q[6:4];
            rem_d   = rd_q[3:0];
            div_d   = '0;
            state_d = (rd_q[3:0] == 4'd0) ? StNext : StPlot;
         end
         StPlot: begin
            if (slot) begin
               x_d   = cx_q;
               y_d   = cy_q;
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  state_d = StNext;
               end else begin
                  cx_d  = cx_q + step_x;
                  cy_d  = cy_q + step_y;
                  div_d = '0;
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StNext: begin
            if (({1'b0, idx_q} + (IdxW+1)'(1)) == num_q) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + IdxW'(1);
               state_d = StLoad;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort beats a pixel slot in the same cycle: the last-plotted position is kept.
      if (abort && (state_q inside {StLoad, StPlot, StNext})) begin
         state_d = StIdle;
         x_d     = x_q;
         y_d     = y_q;
      end
   end

   always_comb begin
      busy   = state_q inside {StLoad, StPlot, StNext};
      done   = (state_q == StDone) || zdone_q;
      plot   = slot && !abort && ({1'b0, cx_q} < XLim) && ({1'b0, cy_q} < YLim);
      x      = (slot && !abort) ? cx_q : x_q;
      y      = (slot && !abort) ? cy_q : y_q;
      colour = colour_q;
   end

endmodule

// File: tb/tb_glyph_stroke_plotter.sv
// Directed bench for glyph_stroke_plotter: one instance at TICK_DIV=4, one at TICK_DIV=2 on shared inputs.
module tb_glyph_stroke_plotter;

   logic        clk = 1'b0;
   logic        reset;
   logic        seg_we;
   logic [2:0]  seg_addr;
   logic [14:0] seg_data;
   logic        start;
   logic [3:0]  num_seg;
   logic [7:0]  x0;
   logic [6:0]  y0;
   logic [2:0]  colour_in;
   logic        erase;
   logic        abort;

   logic [7:0]  d_x, r_x;
   logic [6:0]  d_y, r_y;
   logic [2:0]  d_col, r_col;
   logic        d_plot, r_plot, d_busy, r_busy, d_done, r_done;

   always #5 clk = ~clk;

   glyph_stroke_plotter #(.TICK_DIV(4)) u_dut (
      .clk(clk), .reset(reset), .seg_we(seg_we), .seg_addr(seg_addr), .seg_data(seg_data),
      .start(start), .num_seg(num_seg), .x0(x0), .y0(y0), .colour_in(colour_in),
      .erase(erase), .abort(abort), .x(d_x), .y(d_y), .colour(d_col), .plot(d_plot),
      .busy(d_busy), .done(d_done)
   );

   glyph_stroke_plotter #(.TICK_DIV(2)) u_r (
      .clk(clk), .reset(reset), .seg_we(seg_we), .seg_addr(seg_addr), .seg_data(seg_data),
      .start(start), .num_seg(num_seg), .x0(x0), .y0(y0), .colour_in(colour_in),
      .erase(erase), .abort(abort), .x(r_x), .y(r_y), .colour(r_col), .plot(r_plot),
      .busy(r_busy), .done(r_done)
   );

   int ncmp = 0;
   int nfail = 0;
   int plots, dones, done_cyc, busy_first, busy_last;
   int          pc   [64];
   logic [7:0]  px   [64];
   logic [6:0]  py   [64];
   logic [2:0]  pcol [64];

   // Golden pixel list for the R-shaped table, origin (10,20).
   int gx [14] = '{10, 10, 10, 10, 10, 11, 12, 13, 12, 11, 12, 11, 12, 11};
   int gy [14] = '{20, 21, 22, 23, 24, 20, 20, 21, 22, 23, 24, 22, 24, 23};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wseg(input int a, input int dx, input int dy, input int dir, input int len);
      @(posedge clk); #1;
      seg_addr = 3'(a);
      seg_data = {4'(dx), 4'(dy), 3'(dir), 4'(len)};
      seg_we   = 1'b1;
      @(posedge clk); #1;
      seg_we   = 1'b0;
   endtask

   // Pulses start so it is sampled at edge 0; cycle c is the interval after edge c-1.
   task automatic run(input bit sel, input int maxc, input int abort_cyc, input int poke_cyc);
      logic p, b, dn;
      logic [7:0] xx;
      logic [6:0] yy;
      logic [2:0] cc;
      plots = 0; dones = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
      @(posedge clk); #1;
      start = 1'b1;
      for (int c = 1; c <= maxc; c++) begin
         @(posedge clk); #1;
         start  = (c == poke_cyc);
         seg_we = (c == poke_cyc);
         abort  = (c == abort_cyc);
         if (c == poke_cyc) x0 = x0 + 8'd7;
         @(negedge clk);
         if (sel) begin p = r_plot; b = r_busy; dn = r_done; xx = r_x; yy = r_y; cc = r_col; end
         else     begin p = d_plot; b = d_busy; dn = d_done; xx = d_x; yy = d_y; cc = d_col; end
         if (p && plots < 64) begin
            pc[plots] = c; px[plots] = xx; py[plots] = yy; pcol[plots] = cc;
            plots++;
         end
         if (b) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
         end
         if (dn) begin dones++; done_cyc = c; end
      end
      start = 1'b0; seg_we = 1'b0; abort = 1'b0;
   endtask

   initial begin
      reset = 1'b1; seg_we = 1'b0; seg_addr = '0; seg_data = '0; start = 1'b0;
      num_seg = '0; x0 = '0; y0 = '0; colour_in = '0; erase = 1'b0; abort = 1'b0;
      #12;
      chk("rst_x", d_x, 0);
      chk("rst_y", d_y, 0);
      chk("rst_colour", d_col, 0);
      chk("rst_plot", d_plot, 0);
      chk("rst_busy", d_busy, 0);
      chk("rst_done", d_done, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Single east stroke from (79,63): plots at 5,9,13,17, done at 19.
      wseg(0, 0, 0, 0, 4);
      num_seg = 4'd1; x0 = 8'd79; y0 = 7'd63; colour_in = 3'b011; erase = 1'b0;
      run(1'b0, 25, 0, 0);
      chk("a_plots", plots, 4);
      chk("a_pc0", pc[0], 5);
      chk("a_pc1", pc[1], 9);
      chk("a_pc3", pc[3], 17);
      chk("a_x0", px[0], 79);
      chk("a_x3", px[3], 82);
      chk("a_y2", py[2], 63);
      chk("a_col0", pcol[0], 3);
      chk("a_done_cyc", done_cyc, 19);
      chk("a_dones", dones, 1);
      chk("a_busy_first", busy_first, 1);
      chk("a_busy_last", busy_last, 18);
      chk("a_col_hold", d_col, 3);

      // R glyph at TICK_DIV=2, including a len=0 entry: 8*2 + 14*2 = 44 busy cycles.
      wseg(0, 0, 0, 2, 5);
      wseg(1, 1, 0, 0, 2);
      wseg(2, 3, 1, 2, 1);
      wseg(3, 2, 2, 3, 1);
      wseg(4, 1, 2, 4, 0);
      wseg(5, 1, 3, 1, 2);
      wseg(6, 1, 2, 0, 1);
      wseg(7, 2, 4, 5, 2);
      num_seg = 4'd8; x0 = 8'd10; y0 = 7'd20; colour_in = 3'b100; erase = 1'b0;
      run(1'b1, 80, 0, 0);
      chk("r_plots", plots, 14);
      chk("r_dones", dones, 1);
      chk("r_done_cyc", done_cyc, 45);
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("r_x%0d", i), px[i], gx[i]);
         chk($sformatf("r_y%0d", i), py[i], gy[i]);
      end

      // Erase run with an oversized count, which clamps to 8 segments.
      num_seg = 4'd12; erase = 1'b1; colour_in = 3'b101;
      run(1'b1, 80, 0, 0);
      chk("e_plots", plots, 14);
      chk("e_done_cyc", done_cyc, 45);
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("e_x%0d", i), px[i], gx[i]);
         chk($sformatf("e_y%0d", i), py[i], gy[i]);
         chk($sformatf("e_col%0d", i), pcol[i], 0);
      end

      // Clip at the right edge: 158,159 strobe; 160,161 slots stay silent.
      wseg(0, 0, 0, 0, 4);
      num_seg = 4'd1; x0 = 8'd158; y0 = 7'd10; colour_in = 3'b010; erase = 1'b0;
      run(1'b0, 25, 0, 0);
      chk("c_plots", plots, 2);
      chk("c_pc1", pc[1], 9);
      chk("c_x1", px[1], 159);
      chk("c_done_cyc", done_cyc, 19);

      // Abort on the second pixel slot of a 3-segment run, then a clean rerun.
      wseg(0, 0, 0, 0, 3);
      wseg(1, 0, 1, 0, 3);
      wseg(2, 0, 2, 0, 3);
      num_seg = 4'd3; x0 = 8'd20; y0 = 7'd30;
      run(1'b0, 50, 9, 0);
      chk("ab_plots", plots, 1);
      chk("ab_busy_last", busy_last, 9);
      chk("ab_dones", dones, 0);
      run(1'b0, 50, 0, 0);
      chk("rr_plots", plots, 9);
      chk("rr_pc0", pc[0], 5);
      chk("rr_x0", px[0], 20);
      chk("rr_y0", py[0], 30);
      chk("rr_x8", px[8], 22);
      chk("rr_y8", py[8], 32);
      chk("rr_done_cyc", done_cyc, 43);

      // Zero-length run: done the next cycle, nothing else.
      num_seg = 4'd0;
      run(1'b0, 6, 0, 0);
      chk("z_dones", dones, 1);
      chk("z_done_cyc", done_cyc, 1);
      chk("z_plots", plots, 0);
      chk("z_busy_first", busy_first, -1);

      // start and abort together in idle: abort wins.
      num_seg = 4'd3;
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("sa_busy", d_busy, 0);
      @(negedge clk);
      chk("sa_busy2", d_busy, 0);

      // Table write and start while busy are both dropped.
      wseg(0, 0, 0, 0, 4);
      seg_addr = 3'd0; seg_data = 15'h7fff;
      num_seg = 4'd1; x0 = 8'd79; y0 = 7'd63; colour_in = 3'b001;
      run(1'b0, 25, 0, 3);
      chk("p_plots", plots, 4);
      chk("p_x0", px[0], 79);
      chk("p_x3", px[3], 82);
      chk("p_done_cyc", done_cyc, 19);
      chk("p_dones", dones, 1);
      x0 = 8'd79;
      run(1'b0, 25, 0, 0);
      chk("q_plots", plots, 4);
      chk("q_x0", px[0], 79);
      chk("q_y0", py[0], 63);

      // Asynchronous reset mid-run.
      num_seg = 4'd1; x0 = 8'd5; y0 = 7'd5; colour_in = 3'b110;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("mr_busy_pre", d_busy, 1);
      chk("mr_x_pre", d_x, 82);
      reset = 1'b1;
      #1;
      chk("mr_busy", d_busy, 0);
      chk("mr_x", d_x, 0);
      chk("mr_colour", d_col, 0);
      chk("mr_plot", d_plot, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mr_done", d_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
